// File: rtl/tick_gen_multi_if.sv
// Configuration and output bundle for the multi-channel tick generator.
// The controller drives enables and config writes. The generator drives tick, sq and done.
interface tick_gen_multi_if #(
  parameter int CH      = 4,
  parameter int CH_BITS = 2,
  parameter int WIDTH   = 24
);
  logic               ce;
  logic [CH-1:0]      ch_en;
  logic               wr;
  logic [CH_BITS-1:0] wr_ch;
  logic [WIDTH-1:0]   wr_div;
  logic               wr_mode;
  logic [CH-1:0]      tick;
  logic [CH-1:0]      sq;
  logic [CH-1:0]      done;

  modport master (
    output ce, ch_en, wr, wr_ch, wr_div, wr_mode,
    input  tick, sq, done
  );

  modport slave (
    input  ce, ch_en, wr, wr_ch, wr_div, wr_mode,
    output tick, sq, done
  );
endinterface

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator.
// Each channel divides clk by (div+1) active cycles and produces three outputs:
// a 1-cycle tick, a square wave that toggles on every terminal count, and a
// one-shot done flag. A channel in one-shot mode freezes after its first tick
// and stays frozen until it is rewritten.
module tick_gen_multi #(
  parameter int               CH      = 4,
  parameter int               CH_BITS = 2,
  parameter int               WIDTH   = 24,
  parameter logic [WIDTH-1:0] DEF_DIV = {WIDTH{1'b1}}
) (
  input  logic            clk,
  input  logic            clr,
  tick_gen_multi_if.slave bus
);

  logic [WIDTH-1:0] div_q [CH];
  logic [WIDTH-1:0] cnt_q [CH];
  logic [CH-1:0]    mode_q;
  logic [CH-1:0]    tick_q;
  logic [CH-1:0]    sq_q;
  logic [CH-1:0]    done_q;

  logic [CH-1:0]    active;
  logic [CH-1:0]    wr_hit;
  logic [CH-1:0]    term;

  // Per-channel decode: whether the channel counts, whether it is being rewritten,
  // and whether it sits at terminal count.
  // An out-of-range wr_ch matches no channel, so the write is dropped.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    active = '0;
    wr_hit = '0;
    term   = '0;
    for (int i = 0; i < CH; i++) begin
      active[i] = bus.ce && bus.ch_en[i] && !(mode_q[i] && done_q[i]);
      wr_hit[i] = bus.wr && (bus.wr_ch == CH_BITS'(i));
      term[i]   = (cnt_q[i] == div_q[i]);
    end
  end

  // Channel state update. clr has the highest priority, then a config write,
  // then normal counting.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment, so every channel sees pre-edge values.
    if (clr) begin
      for (int i = 0; i < CH; i++) begin
        div_q[i] <= DEF_DIV;
        cnt_q[i] <= '0;
      end
      mode_q <= '0;
      tick_q <= '0;
      sq_q   <= '0;
      done_q <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (wr_hit[i]) begin
          // A write re-arms the channel and suppresses any tick due on the same edge.
          div_q[i]  <= bus.wr_div;
          mode_q[i] <= bus.wr_mode;
          cnt_q[i]  <= '0;
          tick_q[i] <= 1'b0;
          sq_q[i]   <= 1'b0;
          done_q[i] <= 1'b0;
        end else if (active[i]) begin
          if (term[i]) begin
            cnt_q[i]  <= '0;
            tick_q[i] <= 1'b1;
            sq_q[i]   <= ~sq_q[i];
            if (mode_q[i]) begin
              done_q[i] <= 1'b1;
            end
          end else begin
            cnt_q[i]  <= cnt_q[i] + WIDTH'(1);
            tick_q[i] <= 1'b0;
          end
        end else begin
          // Paused or frozen: cnt and sq hold, and tick drops.
          tick_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.tick = tick_q;
  assign bus.sq   = sq_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_tick_gen_multi.sv
// Self-checking bench for tick_gen_multi.
// The reference model tracks the number of active cycles each channel has
// counted since it was last armed. tick, sq and done are then derived
// arithmetically from that count and the channel's period.
module tb_tick_gen_multi;
  localparam int CH      = 4;
  localparam int CH_BITS = 3;
  localparam int WIDTH   = 4;
  localparam int DEF     = 15;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  tick_gen_multi_if #(.CH(CH), .CH_BITS(CH_BITS), .WIDTH(WIDTH)) bus ();

  tick_gen_multi #(
    .CH(CH), .CH_BITS(CH_BITS), .WIDTH(WIDTH), .DEF_DIV(4'hF)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int            m_div  [CH];
  bit            m_mode [CH];
  int            m_n    [CH];
  logic [CH-1:0] m_tick;

  function automatic logic [CH-1:0] exp_sq();
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) r[i] = ((m_n[i] / (m_div[i] + 1)) % 2) == 1;
    return r;
  endfunction

  function automatic logic [CH-1:0] exp_done();
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) r[i] = m_mode[i] && (m_n[i] >= m_div[i] + 1);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_div[i]  = DEF;
      m_mode[i] = 1'b0;
      m_n[i]    = 0;
    end
    m_tick = '0;
  endtask

  task automatic check(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Run one clock edge. Advance the model with the inputs that were present
  // at that edge, then compare all outputs shortly after the edge.
  task automatic cycle(input string tag);
    @(posedge clk);
    if (clr) begin
      model_reset();
    end else begin
      for (int i = 0; i < CH; i++) begin
        automatic bit fired = m_mode[i] && (m_n[i] >= m_div[i] + 1);
        if (bus.wr && int'(bus.wr_ch) == i) begin
          m_div[i]  = int'(bus.wr_div);
          m_mode[i] = bus.wr_mode;
          m_n[i]    = 0;
          m_tick[i] = 1'b0;
        end else if (bus.ce && bus.ch_en[i] && !fired) begin
          m_n[i]++;
          m_tick[i] = (m_n[i] % (m_div[i] + 1)) == 0;
        end else begin
          m_tick[i] = 1'b0;
        end
      end
    end
    #1;
    check({tag, "_tick"}, bus.tick, m_tick);
    check({tag, "_sq"},   bus.sq,   exp_sq());
    check({tag, "_done"}, bus.done, exp_done());
  endtask

  task automatic write_cfg(input int ch, input int d, input bit m, input string tag);
    bus.wr      = 1'b1;
    bus.wr_ch   = CH_BITS'(ch);
    bus.wr_div  = WIDTH'(d);
    bus.wr_mode = m;
    cycle(tag);
    bus.wr = 1'b0;
  endtask

  initial begin
    int first;
    int cnt;
    int last;
    logic [CH-1:0] quiet;

    model_reset();
    clr         = 1'b1;
    bus.ce      = 1'b0;
    bus.ch_en   = '0;
    bus.wr      = 1'b0;
    bus.wr_ch   = '0;
    bus.wr_div  = '0;
    bus.wr_mode = 1'b0;

    // 1. Reset, then the default divider gives its first tick after 16 active cycles.
    cycle("reset");
    cycle("reset");
    clr       = 1'b0;
    bus.ce    = 1'b1;
    bus.ch_en = 4'b1111;
    first = -1;
    for (int c = 1; c <= 16; c++) begin
      cycle("default");
      if (bus.tick[0] && first < 0) first = c;
    end
    check_int("default_first_tick", first, 16);

    // 2. Periodic mode with div = 3 on ch0 only.
    bus.ch_en = 4'b0001;
    write_cfg(0, 3, 1'b0, "wr_ch0");
    cnt = 0; last = 0; quiet = '0;
    for (int c = 1; c <= 12; c++) begin
      cycle("ch0_div3");
      if (bus.tick[0]) begin cnt++; last = c; end
      quiet |= bus.tick & 4'b1110;
    end
    check_int("ch0_tick_count", cnt, 3);
    check_int("ch0_last_tick", last, 12);
    check("ch123_quiet", quiet, 4'b0000);

    // 3. div = 0 on ch1 ticks every cycle. Dropping ce freezes every channel.
    bus.ch_en = 4'b0011;
    write_cfg(1, 0, 1'b0, "wr_ch1");
    cnt = 0;
    for (int c = 1; c <= 6; c++) begin
      cycle("ch1_div0");
      if (bus.tick[1]) cnt++;
    end
    check_int("ch1_continuous", cnt, 6);
    bus.ce = 1'b0;
    quiet = '0;
    for (int c = 1; c <= 5; c++) begin
      cycle("ce_low");
      quiet |= bus.tick;
    end
    check("ce_low_no_tick", quiet, 4'b0000);
    bus.ce = 1'b1;

    // 4. One-shot mode on ch2, followed by a re-arm.
    bus.ch_en = 4'b0100;
    write_cfg(2, 2, 1'b1, "wr_ch2");
    cnt = 0; first = -1;
    for (int c = 1; c <= 20; c++) begin
      cycle("oneshot");
      if (bus.tick[2]) begin cnt++; if (first < 0) first = c; end
    end
    check_int("oneshot_count", cnt, 1);
    check_int("oneshot_at", first, 3);
    check_int("oneshot_done", int'(bus.done[2]), 1);
    write_cfg(2, 2, 1'b1, "rearm_ch2");
    check_int("rearm_done_clear", int'(bus.done[2]), 0);
    first = -1;
    for (int c = 1; c <= 5; c++) begin
      cycle("rearm");
      if (bus.tick[2] && first < 0) first = c;
    end
    check_int("rearm_tick_at", first, 3);

    // 5. A write on the terminal-count edge wins. An out-of-range wr_ch is ignored.
    bus.ch_en = 4'b0001;
    write_cfg(0, 3, 1'b0, "wr_ch0b");
    for (int k = 0; k < 8; k++) begin
      if (m_n[0] % 4 == 3) break;
      cycle("to_term");
    end
    check_int("at_terminal", m_n[0] % 4, 3);
    write_cfg(0, 3, 1'b0, "wr_on_term");
    check_int("wr_on_term_no_tick", int'(bus.tick[0]), 0);
    first = -1;
    for (int c = 1; c <= 6; c++) begin
      cycle("after_term_wr");
      if (bus.tick[0] && first < 0) first = c;
    end
    check_int("after_term_wr_tick", first, 4);
    write_cfg(CH, 1, 1'b1, "wr_out_of_range");
    for (int c = 1; c <= 4; c++) cycle("post_ignored");

    // 6. clr mid-count, then a pause in ch_en delays the tick without losing counts.
    bus.ch_en = 4'b1000;
    write_cfg(3, 5, 1'b0, "wr_ch3");
    cycle("ch3_cnt");
    cycle("ch3_cnt");
    clr = 1'b1;
    cycle("mid_clr");
    clr = 1'b0;
    check("mid_clr_tick", bus.tick, 4'b0000);
    check("mid_clr_sq", bus.sq, 4'b0000);
    bus.ch_en = 4'b0001;
    write_cfg(0, 5, 1'b0, "wr_ch0c");
    first = -1;
    for (int c = 1; c <= 20; c++) begin
      bus.ch_en = (c >= 4 && c <= 6) ? 4'b0000 : 4'b0001;
      cycle("pause");
      if (bus.tick[0] && first < 0) first = c;
    end
    check_int("pause_delay", first, 9);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      clr         = ($urandom_range(0, 59) == 0);
      bus.ce      = ($urandom_range(0, 7) != 0);
      bus.ch_en   = CH'($urandom);
      bus.wr      = ($urandom_range(0, 9) == 0);
      bus.wr_ch   = CH_BITS'($urandom_range(0, 7));
      bus.wr_div  = WIDTH'($urandom_range(0, 6));
      bus.wr_mode = $urandom_range(0, 1) == 1;
      cycle("random");
    end
    clr    = 1'b0;
    bus.wr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
